// File: rtl/npc_gen_pkg.sv
// Shared definitions for the next-PC generator: width/reset defaults,
// fetch-redirect state encoding and the sequential PC increment.
package npc_gen_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } npc_state_e;

endpackage

// File: rtl/npc_target_adder.sv
// Branch/jump target former: base select, add immediate, clear bit 0 for jalr.
module npc_target_adder
    import npc_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            [XLEN-1:0] pc_ex_i,
    input  logic            [XLEN-1:0] rs1_ex_i,
    input  logic signed     [XLEN-1:0] imm_ex_i,
    input  logic                       jalr_i,
    output logic            [XLEN-1:0] target_o
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    always_comb begin
        base = jalr_i ? rs1_ex_i : pc_ex_i;
        // Two's-complement add wraps modulo 2^XLEN, so the signed imm needs no extension.
        sum  = base + imm_ex_i;
        target_o = {sum[XLEN-1:1], sum[0] & ~jalr_i};
    end

endmodule

// File: rtl/npc_gen.sv
// IF-stage PC register and fetch-redirect controller with stall-pending redirect.
// Optional feature: define NPC_MISALIGN_TRAP_EN to refuse misaligned targets and freeze fetch.
module npc_gen
    import npc_gen_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    input  logic            ex_valid,
    input  logic            PCAsrc,
    input  logic            PCBsrc,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] rs1_ex,
    input  logic [XLEN-1:0] imm_ex,
    output logic [XLEN-1:0] pc_if,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic [31:0]     redirect_cnt,
    output logic            misalign_err
);

    npc_state_e      state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_q;
    logic [31:0]     cnt_q;
    logic [31:0]     cnt_d;
    logic [XLEN-1:0] target;
    logic            req;
    logic            bad_tgt;
    logic            frozen;

    npc_target_adder #(.XLEN(XLEN)) u_target (
        .pc_ex_i  (pc_ex),
        .rs1_ex_i (rs1_ex),
        .imm_ex_i (imm_ex),
        .jalr_i   (PCBsrc),
        .target_o (target)
    );

    assign req = ex_valid & PCAsrc;

`ifdef NPC_MISALIGN_TRAP_EN
    logic err_q;

    assign bad_tgt      = req & (target[1:0] != 2'b00);
    assign frozen       = err_q;
    assign misalign_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_tgt) begin
            err_q <= 1'b1;
        end
    end
`else
    assign bad_tgt      = 1'b0;
    assign frozen       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Kill the two younger slots on a redirect, and again when a held redirect finally lands.
    always_comb begin
        flush_ifid = ~rst & (req | ((state_q == PEND) & ~stall_if));
        flush_idex = flush_ifid;
        cnt_d      = cnt_q + {31'd0, req};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (!frozen && !bad_tgt) begin
                unique case (state_q)
                    RUN: begin
                        if (req && stall_if) begin
                            pend_q  <= target;
                            state_q <= PEND;
                        end else if (req) begin
                            pc_q <= target;
                        end else if (!stall_if) begin
                            pc_q <= pc_q + PC_STEP[XLEN-1:0];
                        end
                    end
                    PEND: begin
                        if (stall_if) begin
                            if (req) pend_q <= target;
                        end else begin
                            pc_q    <= req ? target : pend_q;
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign pc_if        = pc_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: doc/npc_gen.md
# npc_gen

Next-PC generator and fetch-redirect controller for the five-stage RISC-V pipeline. It owns the IF-stage PC register and consumes the PCAsrc/PCBsrc select pair produced by the EX-stage branch-condition unit. It forms the branch/jump target and steers the PC to that target. It also generates the IF/ID and ID/EX flush strobes, and holds a pending redirect when the front end is stalled.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall_if  input  1  hazard unit: hold PC this cycle
- ex_valid  input  1  EX stage holds a real (non-bubble) instruction
- PCAsrc  input  1  1 = take redirect (target base + imm)
- PCBsrc  input  1  base select: 0 = pc_ex, 1 = rs1_ex (jalr)
- pc_ex  input  XLEN  PC of EX-stage instruction
- rs1_ex  input  XLEN  forwarded rs1 value in EX
- imm_ex  input  XLEN  sign-extended immediate in EX
- pc_if  output  XLEN  current fetch address (registered)
- flush_ifid  output  1  kill IF/ID contents at next edge
- flush_idex  output  1  kill ID/EX contents at next edge
- redirect_cnt  output  32  number of accepted redirects (wraps)
- misalign_err  output  1  sticky misaligned-target flag (macro-dependent)

## Operation
- Redirect request: `req = ex_valid & PCAsrc`.
- Target computation:
  - base = PCBsrc ? rs1_ex : pc_ex.
  - target = base + imm_ex, modulo 2^XLEN.
  - When PCBsrc=1, bit 0 is cleared (jalr rule).
- Reset: pc_if=RESET_PC, state=RUN, pending target=0, redirect_cnt=0, misalign_err=0. flush_ifid and flush_idex are 0 while rst is high.
- RUN state:
  - req & !stall_if: pc_if <= target.
  - req & stall_if: capture target into pend_tgt; go to PEND; pc_if holds.
  - !req & !stall_if: pc_if <= pc_if + 4.
  - !req & stall_if: pc_if holds.
- PEND state:
  - stall_if=1: hold. A new req overwrites pend_tgt, and the newest request wins.
  - stall_if=0: pc_if <= pend_tgt, or the new target if req is also asserted this cycle; return to RUN.
- Flush outputs:
  - Combinational, with flush_ifid = flush_idex = req.
  - Asserted in the same cycle as req, regardless of stall_if.
  - Both are also asserted in the cycle PEND exits, so anything fetched during the stall is killed.
- redirect_cnt increments by 1 on every cycle where req=1, including overwrites in PEND.
- PCAsrc=0 with PCBsrc=1 is treated as no request.

## Timing
- Redirect latency is 1 edge: req in cycle N gives pc_if=target in cycle N+1, when unstalled.
- The instructions in IF and ID during cycle N are flushed, a penalty of 2 bubbles.
- pc_if is purely registered, with no combinational path from inputs.
- If rst is asserted mid-PEND, the pending target is discarded and pc_if=RESET_PC asynchronously.

## Configuration
- NPC_MISALIGN_TRAP_EN defined:
  - A req whose target[1:0] != 0 is not taken; pc_if holds.
  - misalign_err sets, stays sticky until rst, and freezes pc_if.
  - Flushes still assert.
- NPC_MISALIGN_TRAP_EN undefined:
  - misalign_err is tied to 0.
  - Target bits [1:0] are used as computed, except bit 0 is cleared for jalr.

## Structure
- Shared package holds:
  - the XLEN and RESET_PC defaults;
  - the state enum {RUN, PEND};
  - a PC_STEP=4 constant.
- One sub-module: npc_target_adder, which does base mux, add and jalr bit-0 clear; it is purely combinational.
- The state register, PC register, pending register and counter live in npc_gen.

## Test plan
- Reset then 3 unstalled cycles with no req:
  - pc_if = 0x3000, 0x3004, 0x3008, 0x300C.
- Branch taken:
  - pc_ex=0x3010, imm=0xFFFFFFF0, PCAsrc=1, PCBsrc=0, ex_valid=1.
  - Response: flushes=1 that cycle, next pc_if=0x3000, redirect_cnt=1.
- jalr:
  - rs1_ex=0x4001, imm=0x4, PCAsrc=PCBsrc=1.
  - Response: next pc_if=0x4004 (bit 0 cleared).
- Stall with overwrite:
  - req target 0x5000 with stall_if=1 for 3 cycles, then a second req to 0x6000 in stall cycle 2.
  - Response: pc_if holds through the stall; when the stall drops, flushes=1 and next pc_if=0x6000; redirect_cnt=2.
- ex_valid=0 with PCAsrc=1:
  - Response: no flush, pc_if+4, counter unchanged.
- Macro on, target 0x3002 via PCBsrc=0:
  - Response: misalign_err=1 and pc_if frozen until rst.
  - After rst pulse: pc_if=0x3000 and err=0.
